// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin requester bank.
package rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OWN  = 2'd2
  } port_state_e;

  localparam int DEF_NUM_PORTS = 4;

  // True when the vector is all-zero or has exactly one bit set.
  function automatic bit onehot0(input logic [31:0] vec);
    return (vec & (vec - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/rr_req_port.sv
// One requesting client: job queue counter, REQ/OWN FSM and ownership hold counter.
module rr_req_port
  import rr_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  input  logic        grant_ok,
  output logic        job_ready,
  output logic        request,
  output logic        busy,
  output logic        done,
  output port_state_e state
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  port_state_e       state_q, state_d;
  logic [CNT_W-1:0]  pending_q, pending_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              done_q, done_d;
  logic              acc, start;

  assign job_ready = (pending_q != CNT_MAX);
  assign acc       = job_valid & job_ready;
  // An empty idle port starts straight from the accepted job, bypassing the queue.
  assign start     = (state_q == ST_IDLE) & ((pending_q != '0) | acc);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    pending_d = pending_q + {{(CNT_W-1){1'b0}}, acc} - {{(CNT_W-1){1'b0}}, start};
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (grant_ok) begin
          state_d = ST_OWN;
          hold_d  = HOLD_LOAD;
        end
      end
      ST_OWN: begin
        if (hold_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      hold_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
    end
  end

  assign request = (state_q == ST_REQ);
  assign busy    = (state_q == ST_OWN);
  assign done    = done_q;
  assign state   = state_q;

endmodule

// File: rtl/rr_requester_bank.sv
// Bank of round-robin requesters with grant qualification and sticky protocol-error flag.
module rr_requester_bank
  import rr_pkg::*;
#(
  parameter int NUM_PORTS   = DEF_NUM_PORTS,
  parameter int CNT_W       = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] job_valid_i,
  output logic [NUM_PORTS-1:0] job_ready_o,
  input  logic [NUM_PORTS-1:0] grant_i,
  output logic [NUM_PORTS-1:0] request_o,
  output logic [NUM_PORTS-1:0] busy_o,
  output logic [NUM_PORTS-1:0] done_o,
  output logic                 err_o
);

  port_state_e          port_state [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_req;
  logic [NUM_PORTS-1:0] grant_ok;
  logic                 gvalid;
  logic                 err_q;

  // A malformed grant vector is discarded entirely for that cycle.
  assign gvalid   = onehot0(32'(grant_i));
  assign grant_ok = gvalid ? grant_i : '0;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    assign in_req[k] = (port_state[k] == ST_REQ);

    rr_req_port #(
      .CNT_W       (CNT_W),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_port (
      .clk       (clk),
      .reset     (reset),
      .job_valid (job_valid_i[k]),
      .grant_ok  (grant_ok[k]),
      .job_ready (job_ready_o[k]),
      .request   (request_o[k]),
      .busy      (busy_o[k]),
      .done      (done_o[k]),
      .state     (port_state[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (!gvalid || ((grant_i & ~in_req) != '0)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_rr_requester_bank.sv
// Directed bench for rr_requester_bank with hand-computed expectations.
module tb_rr_requester_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] job_valid_i;
  logic [3:0] job_ready_o;
  logic [3:0] grant_i;
  logic [3:0] request_o;
  logic [3:0] busy_o;
  logic [3:0] done_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;

  rr_requester_bank #(
    .NUM_PORTS   (4),
    .CNT_W       (4),
    .HOLD_CYCLES (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .job_valid_i (job_valid_i),
    .job_ready_o (job_ready_o),
    .grant_i     (grant_i),
    .request_o   (request_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    job_valid_i = 4'b0000;
    grant_i = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int gcount;
    int done0, done1;
    int idx;
    logic [3:0] g;

    // Reset state
    do_reset();
    chk("rst_request", request_o, 4'b0000);
    chk("rst_busy", busy_o, 4'b0000);
    chk("rst_done", done_o, 4'b0000);
    chk("rst_err", err_o, 1'b0);
    chk("rst_ready", job_ready_o, 4'b1111);

    // Single job on port0
    job_valid_i = 4'b0001;
    tick();
    job_valid_i = 4'b0000;
    chk("single_req", request_o, 4'b0001);
    chk("single_busy0", busy_o, 4'b0000);
    grant_i = 4'b0001;
    tick();
    grant_i = 4'b0000;
    chk("single_own1_busy", busy_o, 4'b0001);
    chk("single_own1_req", request_o, 4'b0000);
    tick();
    chk("single_own2_busy", busy_o, 4'b0001);
    tick();
    chk("single_own3_busy", busy_o, 4'b0001);
    chk("single_own3_done", done_o, 4'b0000);
    tick();
    chk("single_done", done_o, 4'b0001);
    chk("single_done_busy", busy_o, 4'b0000);
    tick();
    chk("single_after_done", done_o, 4'b0000);
    chk("single_after_req", request_o, 4'b0000);
    chk("single_err", err_o, 1'b0);

    // Alternating load on ports 0 and 2 with a round-robin grant model
    last = 3;
    gcount = 0;
    done0 = 0;
    done1 = 0;
    for (int i = 0; i < 60; i++) begin
      job_valid_i = (i < 4) ? 4'b0101 : 4'b0000;
      g = 4'b0000;
      if (busy_o == 4'b0000 && request_o != 4'b0000) begin
        for (int j = 1; j <= 4; j++) begin
          idx = (last + j) % 4;
          if (g == 4'b0000 && request_o[idx]) begin
            g[idx] = 1'b1;
            last = idx;
          end
        end
      end
      grant_i = g;
      if (g != 4'b0000) begin
        chk("alt_grant", g, (gcount % 2 == 0) ? 4'b0001 : 4'b0100);
        gcount++;
      end
      tick();
      chk("alt_busy_onehot", ($countones(busy_o) <= 1), 1'b1);
      if (done_o[0]) done0++;
      if (done_o[2]) done1++;
    end
    grant_i = 4'b0000;
    chk("alt_done_p0", done0, 4);
    chk("alt_done_p2", done1, 4);
    chk("alt_grants", gcount, 8);
    chk("alt_idle_req", request_o, 4'b0000);
    chk("alt_err", err_o, 1'b0);

    // Flood port3 without grants
    do_reset();
    job_valid_i = 4'b1000;
    for (int i = 0; i < 15; i++) tick();
    chk("flood_ready_p14", job_ready_o, 4'b1111);
    tick();
    chk("flood_full", job_ready_o, 4'b0111);
    tick();
    tick();
    chk("flood_full_hold", job_ready_o, 4'b0111);
    chk("flood_req", request_o, 4'b1000);
    job_valid_i = 4'b0000;
    grant_i = 4'b1000;
    tick();
    grant_i = 4'b0000;
    chk("flood_own_busy", busy_o, 4'b1000);
    chk("flood_own_ready", job_ready_o, 4'b0111);
    tick();
    tick();
    tick();
    chk("flood_done", done_o, 4'b1000);
    chk("flood_done_req", request_o, 4'b0000);
    chk("flood_done_ready", job_ready_o, 4'b0111);
    tick();
    chk("flood_ready_back", job_ready_o, 4'b1111);
    chk("flood_rereq", request_o, 4'b1000);
    chk("flood_err", err_o, 1'b0);

    // Grant protocol violations
    do_reset();
    chk("rst2_ready", job_ready_o, 4'b1111);
    job_valid_i = 4'b0011;
    tick();
    job_valid_i = 4'b0000;
    chk("viol_req", request_o, 4'b0011);
    grant_i = 4'b0011;
    tick();
    chk("viol_multi_err", err_o, 1'b1);
    chk("viol_multi_req", request_o, 4'b0011);
    chk("viol_multi_busy", busy_o, 4'b0000);
    grant_i = 4'b0100;
    tick();
    grant_i = 4'b0000;
    chk("viol_stray_err", err_o, 1'b1);
    chk("viol_stray_req", request_o, 4'b0011);
    chk("viol_stray_busy", busy_o, 4'b0000);
    tick();
    chk("viol_sticky", err_o, 1'b1);
    grant_i = 4'b0001;
    tick();
    grant_i = 4'b0000;
    chk("viol_then_grant", busy_o, 4'b0001);

    // Reset during second OWN cycle of port1 with two jobs queued
    do_reset();
    chk("rst3_err", err_o, 1'b0);
    job_valid_i = 4'b0010;
    tick();
    tick();
    tick();
    job_valid_i = 4'b0000;
    chk("mid_req", request_o, 4'b0010);
    grant_i = 4'b0010;
    tick();
    grant_i = 4'b0000;
    chk("mid_own1", busy_o, 4'b0010);
    tick();
    chk("mid_own2", busy_o, 4'b0010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", busy_o, 4'b0000);
    chk("mid_rst_done", done_o, 4'b0000);
    chk("mid_rst_req", request_o, 4'b0000);
    chk("mid_rst_ready", job_ready_o, 4'b1111);
    tick();
    chk("mid_post_done", done_o, 4'b0000);
    chk("mid_post_req", request_o, 4'b0000);
    tick();
    chk("mid_post_req2", request_o, 4'b0000);

    // Bypass job on empty idle port2
    job_valid_i = 4'b0100;
    tick();
    job_valid_i = 4'b0000;
    chk("bypass_req", request_o, 4'b0100);
    grant_i = 4'b0100;
    tick();
    grant_i = 4'b0000;
    chk("bypass_busy", busy_o, 4'b0100);
    tick();
    tick();
    tick();
    chk("bypass_done", done_o, 4'b0100);
    tick();
    chk("bypass_no_rereq", request_o, 4'b0000);
    tick();
    chk("bypass_idle", request_o, 4'b0000);
    chk("bypass_err", err_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
